// File: rtl/sfp_vec3_rsqrt.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : sfp_vec3_rsqrt                                               |
// | Description : Iterative Newton-Raphson reciprocal square root, y=1/sqrt(x) |
// |               Signed fixed point, valid/ready on both sides, one operand   |
// |               in flight, one multiplier shared across SQ/MUL/UPD steps.    |
// | Options     : SFP_RSQRT_EARLY_EXIT_EN - leave the loop as soon as y stops  |
// |               changing (result is bit-identical, latency shrinks).         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module sfp_vec3_rsqrt #(
    parameter int IW    = 8,
    parameter int QW    = 16,
    parameter int OIW   = 4,
    parameter int OQW   = 16,
    parameter int GW    = 4,
    parameter int ITERS = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [IW+QW-1:0]     in_val,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [OIW+OQW-1:0]   out_val,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 clipping,
    output logic                 err
);
    localparam int c_xw  = IW + QW;
    localparam int c_ow  = OIW + OQW;
    localparam int c_yi  = OIW + 2;           // integer bits of y
    localparam int c_yf  = OQW + GW;          // fractional bits of y and t
    localparam int c_yw  = c_yi + c_yf;
    // t keeps extra integer headroom: y*y for y near the top of the output
    // range would overflow y's own format before x*t brings it back near 1.
    localparam int c_tw  = 2 * c_yi + c_yf;
    localparam int c_pw  = 2 * c_tw;
    localparam int c_rw  = c_yw + 1 - GW;
    localparam int c_sw  = c_yw + 1;
    localparam logic [c_tw-1:0] c_three   = c_tw'(3) << c_yf;
    // Any x at or below this gives 1/sqrt(x) >= 2^(OIW-1): known to clip.
    localparam logic [c_xw-1:0] c_clip_x  = c_xw'(1) << (QW - 2 * (OIW - 1));
    localparam logic [c_ow-1:0] c_out_max = {1'b0, {(c_ow-1){1'b1}}};
    localparam logic [c_rw-1:0] c_rnd_max = c_rw'(c_out_max);
    localparam logic [c_sw-1:0] c_half    = c_sw'(1) << (GW - 1);
    localparam logic [3:0]      c_iters   = 4'(ITERS);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_SEED = 3'd1,
        S_SQ   = 3'd2,
        S_MUL  = 3'd3,
        S_UPD  = 3'd4,
        S_DONE = 3'd5
    } state_t;

    state_t                 r_state, w_next;
    logic [c_xw-1:0]        r_x;
    logic [c_yw-1:0]        r_y;
    logic [c_tw-1:0]        r_t;
    logic [3:0]             r_k;
    logic                   r_sat;

    logic signed [c_tw-1:0] w_mul_a, w_mul_b;
    logic signed [c_pw-1:0] w_prod;
    logic [c_yw-1:0]        w_y_upd;
    logic [3:0]             w_k_inc;
    logic                   w_last;
    logic                   w_x_nonpos;
    logic [7:0]             w_msb;
    logic signed [7:0]      w_exp, w_half_exp;
    logic [7:0]             w_pos;
    logic [c_yw-1:0]        w_seed;
    logic [c_sw-1:0]        w_ysum;
    logic [c_rw-1:0]        w_rnd;
    logic                   w_over;
    logic                   w_unused;

    // Seed: exponent of x from its leading one, y0 = 2^-ceil(e/2)
    always_comb begin
        w_msb = '0;
        for (int i = 0; i < c_xw - 1; i++) begin
            if (r_x[i]) w_msb = 8'(i);
        end
        w_exp      = $signed(w_msb - 8'(QW));
        w_half_exp = (w_exp + 8'sd1) >>> 1;
        w_pos      = 8'(c_yf) - $unsigned(w_half_exp);
        w_seed     = c_yw'(1) << w_pos;
    end

    // Shared multiplier operand select: SQ y*y, MUL x*t, UPD y*(3-t)
    always_comb begin
        w_mul_a = $signed({{(c_tw-c_yw){r_y[c_yw-1]}}, r_y});
        w_mul_b = w_mul_a;
        case (r_state)
            S_MUL: begin
                w_mul_a = $signed({{(c_tw-c_xw-GW){r_x[c_xw-1]}}, r_x, {GW{1'b0}}});
                w_mul_b = $signed(r_t);
            end
            S_UPD:   w_mul_b = $signed(c_three - r_t);
            default: ;
        endcase
    end

    assign w_prod     = w_mul_a * w_mul_b;
    // Floor back to y format; the extra bit of shift is the /2 of the update.
    assign w_y_upd    = w_prod[c_yf+1 +: c_yw];
    assign w_k_inc    = r_k + 4'd1;
    assign w_x_nonpos = r_x[c_xw-1] || (r_x == '0);

`ifdef SFP_RSQRT_EARLY_EXIT_EN
    assign w_last = (w_k_inc >= c_iters) || (w_y_upd == r_y);
`else
    assign w_last = (w_k_inc >= c_iters);
`endif

    // Round half up by dropping the guard bits, then range check
    assign w_ysum   = {r_y[c_yw-1], r_y} + c_half;
    assign w_rnd    = w_ysum[c_yw:GW];
    assign w_over   = $signed(w_rnd) > $signed(c_rnd_max);
    assign w_unused = ^{w_prod[c_yf-1:0], w_prod[c_pw-1:c_yf+c_tw], w_ysum[GW-1:0]};

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // Next-state and input handshake
    always_comb begin
        w_next   = r_state;
        in_ready = rst_n && (r_state == S_IDLE);
        case (r_state)
            S_IDLE:  if (in_valid) w_next = S_SEED;
            S_SEED:  w_next = w_x_nonpos ? S_DONE : S_SQ;
            S_SQ:    w_next = S_MUL;
            S_MUL:   w_next = S_UPD;
            S_UPD:   w_next = w_last ? S_DONE : S_SQ;
            S_DONE:  if (out_valid && out_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Datapath and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_x       <= '0;
            r_y       <= '0;
            r_t       <= '0;
            r_k       <= '0;
            r_sat     <= 1'b0;
            out_val   <= '0;
            out_valid <= 1'b0;
            clipping  <= 1'b0;
            err       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_x   <= in_val;
                        r_sat <= 1'b0;
                        err   <= 1'b0;
                    end
                end
                S_SEED: begin
                    r_k <= '0;
                    if (w_x_nonpos) begin
                        err <= 1'b1;
                    end else begin
                        // Clipping inputs iterate on y=0 so latency stays fixed
                        r_sat <= (r_x <= c_clip_x);
                        r_y   <= (r_x <= c_clip_x) ? '0 : w_seed;
                    end
                end
                S_SQ, S_MUL: r_t <= w_prod[c_yf +: c_tw];
                S_UPD: begin
                    r_y <= w_y_upd;
                    r_k <= w_k_inc;
                end
                S_DONE: begin
                    if (!out_valid) begin
                        out_valid <= 1'b1;
                        if (err) begin
                            out_val  <= c_out_max;
                            clipping <= 1'b0;
                        end else if (r_sat || w_over) begin
                            out_val  <= c_out_max;
                            clipping <= 1'b1;
                        end else begin
                            out_val  <= w_rnd[c_ow-1:0];
                            clipping <= 1'b0;
                        end
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sfp_vec3_rsqrt.sv
`default_nettype none
// Bench for sfp_vec3_rsqrt: directed operands, scoreboard of expected results.
module tb_sfp_vec3_rsqrt;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [23:0] in_val = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [19:0] out_val;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic        clipping;
    logic        err;

    int checks = 0;
    int errors = 0;

`ifdef SFP_RSQRT_EARLY_EXIT_EN
    localparam int LAT_EXACT = 5;
    localparam int LAT_ITER  = -1;
`else
    localparam int LAT_EXACT = 14;
    localparam int LAT_ITER  = 14;
`endif
    localparam int LAT_ERR = 2;
    localparam int OMAX    = 524287;

    typedef struct {
        string tag;
        int    val;
        int    tol;
        int    clip;
        int    er;
        int    lat;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    sfp_vec3_rsqrt dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_val    (in_val),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_val   (out_val),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .clipping  (clipping),
        .err       (err)
    );

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_tol(input string tag, input int obs, input int exp, input int tol);
        checks++;
        assert ((obs >= exp - tol) && (obs <= exp + tol)) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d +/- %0d", tag, obs, exp, tol);
        end
    endtask

    // Called #1 after an edge; operand is accepted on the next edge (cycle 0)
    task automatic send(input string tag, input logic [23:0] x, input int val,
                        input int tol, input int clip, input int er, input int lat);
        exp_t e;
        e.tag = tag; e.val = val; e.tol = tol; e.clip = clip; e.er = er; e.lat = lat;
        sb.push_back(e);
        check({tag, "_in_ready"}, int'(in_ready), 1);
        in_val   = x;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic collect();
        exp_t e;
        int   cyc = 0;
        while (!out_valid && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
        end
        if (sb.size() == 0) begin
            check("scoreboard_empty", 0, 1);
        end else begin
            e = sb.pop_front();
            check({e.tag, "_out_valid"}, int'(out_valid), 1);
            if (e.lat >= 0) check({e.tag, "_latency"}, cyc, e.lat);
            check_tol({e.tag, "_out_val"}, int'(out_val), e.val, e.tol);
            check({e.tag, "_clipping"}, int'(clipping), e.clip);
            check({e.tag, "_err"}, int'(err), e.er);
        end
    endtask

    // Output transfer on the next edge, then the stage is idle again
    task automatic finish_xfer(input string tag);
        @(posedge clk); #1;
        check({tag, "_post_valid"}, int'(out_valid), 0);
        check({tag, "_post_ready"}, int'(in_ready), 1);
    endtask

    initial begin
        int exp2;
        int exp9;
        exp2 = $rtoi(65536.0 / $sqrt(2.0) + 0.5);
        exp9 = $rtoi(65536.0 / 3.0 + 0.5);

        // Reset values
        #12;
        check("rst_in_ready", int'(in_ready), 0);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_val", int'(out_val), 0);
        check("rst_clipping", int'(clipping), 0);
        check("rst_err", int'(err), 0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        check("rel_in_ready", int'(in_ready), 1);

        // Main function
        send("x4", 24'h040000, 32768, 0, 0, 0, LAT_EXACT);      collect(); finish_xfer("x4");
        send("x025", 24'd16384, 131072, 0, 0, 0, LAT_EXACT);    collect(); finish_xfer("x025");
        send("x2", 24'd131072, exp2, 2, 0, 0, LAT_ITER);        collect(); finish_xfer("x2");
        send("x9", 24'd589824, exp9, 2, 0, 0, LAT_ITER);        collect(); finish_xfer("x9");
        send("x1lsb", 24'd1, OMAX, 0, 1, 0, LAT_EXACT);         collect(); finish_xfer("x1lsb");
        send("x0", 24'd0, OMAX, 0, 0, 1, LAT_ERR);              collect(); finish_xfer("x0");
        send("xneg1", 24'hFF0000, OMAX, 0, 0, 1, LAT_ERR);      collect(); finish_xfer("xneg1");

        // Backpressure: hold outputs for 10 cycles
        out_ready = 1'b0;
        send("bp", 24'd16384, 131072, 0, 0, 0, LAT_EXACT);
        collect();
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check("bp_hold_valid", int'(out_valid), 1);
            check("bp_hold_val", int'(out_val), 131072);
            check("bp_hold_in_ready", int'(in_ready), 0);
        end
        out_ready = 1'b1;
        finish_xfer("bp");
        send("bp_next", 24'h040000, 32768, 0, 0, 0, LAT_EXACT); collect(); finish_xfer("bp_next");

        // Reset during MUL aborts the operand
        send("abort", 24'h040000, 32768, 0, 0, 0, LAT_EXACT);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("abort_out_valid", int'(out_valid), 0);
        check("abort_in_ready", int'(in_ready), 0);
        check("abort_out_val", int'(out_val), 0);
        void'(sb.pop_front());
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        check("abort_rel_ready", int'(in_ready), 1);
        send("after_abort", 24'h040000, 32768, 0, 0, 0, LAT_EXACT); collect(); finish_xfer("after_abort");

        check("sb_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
